// File: rtl/round_norm_if.sv
// Handshake bundle between an FP add/sub/mul datapath and the normalize/round sequencer.
// The master modport belongs to the producer/consumer side; the slave modport belongs to the sequencer.
interface round_norm_if #(
  parameter int FRAC_W = 27,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [FRAC_W:0]   in_frac;
  logic              round_en;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [FRAC_W-4:0] out_frac;
  logic              out_overflow;
  logic              out_zero;

  modport master (
    output in_valid, in_sign, in_exp, in_frac, round_en, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_frac, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_frac, round_en, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_frac, out_overflow, out_zero
  );
endinterface

// File: rtl/round_norm_sequencer.sv
// Multi-cycle normalize-and-round sequencer: it normalizes one bit per cycle, rounds with RNE or RTZ,
// re-normalizes on a rounding carry, and emits a packed single-precision result.
module round_norm_sequencer #(
  parameter int FRAC_W = 27,
  parameter int EXP_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  round_norm_if.slave   bus
);
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {IDLE, NORM, ROUND, RENORM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [FRAC_W:0]        frac_q, frac_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic                   zero_q, zero_d;
  logic                   sign_q, rnd_q;
  logic                   rnd_up;
  logic [EXP_W-1:0]       oexp_d;
  logic [FRAC_W-4:0]      ofrac_d;
  logic                   ovf_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    frac_d  = frac_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    rnd_up  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = NORM;
          frac_d  = bus.in_frac;
          exp_d   = $signed({2'b00, bus.in_exp});
          zero_d  = 1'b0;
        end
      end
      NORM: begin
        if (frac_q == '0) begin
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (frac_q[FRAC_W]) begin
          // Carry-out: shift right once, folding the two lowest bits into sticky.
          frac_d  = {1'b0, frac_q[FRAC_W:2], frac_q[1] | frac_q[0]};
          exp_d   = exp_q + EXP_ONE;
          state_d = ROUND;
        end else if (!frac_q[FRAC_W-1] && (exp_q > EXP_ONE)) begin
          frac_d  = frac_q << 1;
          exp_d   = exp_q - EXP_ONE;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        rnd_up  = rnd_q && ((frac_q[2:0] > 3'b100) || ((frac_q[2:0] == 3'b100) && frac_q[3]));
        frac_d  = {frac_q[FRAC_W:3] + {{(FRAC_W-3){1'b0}}, rnd_up}, 3'b000};
        state_d = frac_d[FRAC_W] ? RENORM : DONE;
      end
      RENORM: begin
        frac_d  = {1'b0, frac_q[FRAC_W:1]};
        exp_d   = exp_q + EXP_ONE;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Packed result as it will be presented once DONE is entered.
  always_comb begin
    oexp_d  = exp_d[EXP_W-1:0];
    ofrac_d = frac_d[FRAC_W-2:3];
    ovf_d   = 1'b0;
    if (zero_d) begin
      oexp_d  = '0;
      ofrac_d = '0;
    end else if (exp_d >= EXP_MAX) begin
      oexp_d  = '1;
      ofrac_d = '0;
      ovf_d   = 1'b1;
    end else if (!frac_d[FRAC_W-1]) begin
      oexp_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      frac_q           <= '0;
      exp_q            <= '0;
      zero_q           <= 1'b0;
      sign_q           <= 1'b0;
      rnd_q            <= 1'b0;
      bus.in_ready     <= 1'b1;
      bus.out_valid    <= 1'b0;
      bus.out_sign     <= 1'b0;
      bus.out_exp      <= '0;
      bus.out_frac     <= '0;
      bus.out_overflow <= 1'b0;
      bus.out_zero     <= 1'b0;
    end else begin
      state_q       <= state_d;
      frac_q        <= frac_d;
      exp_q         <= exp_d;
      zero_q        <= zero_d;
      bus.in_ready  <= (state_d == IDLE);
      bus.out_valid <= (state_d == DONE);
      if (state_q == IDLE && bus.in_valid) begin
        sign_q <= bus.in_sign;
        rnd_q  <= bus.round_en;
      end
      // Result registers load only on entry to DONE and hold through backpressure.
      if (state_d == DONE && state_q != DONE) begin
        bus.out_sign     <= sign_q;
        bus.out_exp      <= oexp_d;
        bus.out_frac     <= ofrac_d;
        bus.out_overflow <= ovf_d;
        bus.out_zero     <= zero_d;
      end
    end
  end
endmodule
